// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module   : sync_fifo_pkg
// Desc     : Shared types and default thresholds for the single-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_AFULL_THRESH  = 14;
  localparam int DEF_AEMPTY_THRESH = 2;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
// ============================================================================
// Module   : sync_fifo_param_if
// Desc     : Producer/consumer bus of the single-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADD_WIDTH:0]    fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, rd_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, rd_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fill_count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module   : sync_fifo_mem
// Desc     : DEPTH x DATA_WIDTH RAM, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADD_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADD_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Storage is intentionally not reset so it maps onto plain RAM.
  logic [DATA_WIDTH-1:0] mem_q [2**ADD_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Desc     : Single-clock FIFO with occupancy, thresholds, sticky errors, STD/FWFT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         ADD_WIDTH     = 4,
  parameter int         AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int         AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter fifo_mode_e MODE          = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADD_WIDTH;
  localparam logic [ADD_WIDTH:0] c_depth_cnt  = (ADD_WIDTH+1)'(DEPTH);
  localparam logic [ADD_WIDTH:0] c_afull_cnt  = (ADD_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADD_WIDTH:0] c_aempty_cnt = (ADD_WIDTH+1)'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: require 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADD_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADD_WIDTH:0]    count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_accept = bus.wr_en && !full_q;
    rd_accept = bus.rd_en && !empty_q;
    wr_ptr_d  = wr_accept ? wr_ptr_q + ADD_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d  = rd_accept ? rd_ptr_q + ADD_WIDTH'(1) : rd_ptr_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADD_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADD_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they line up with fill_count.
    full_d   = (count_d == c_depth_cnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= c_afull_cnt);
    aempty_d = (count_d <= c_aempty_cnt);
    // A fresh error wins over a same-cycle clear.
    ovf_d = (bus.wr_en && full_q)  ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    unf_d = (bus.rd_en && empty_q) ? 1'b1 : (bus.err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADD_WIDTH  (ADD_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    always_comb begin
      dout_d  = rd_accept ? mem_rdata : dout_q;
      valid_d = rd_accept;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign bus.data_out = dout_q;
    assign bus.rd_valid = valid_q;
  end else begin : g_fwft
    assign bus.data_out = mem_rdata;
    assign bus.rd_valid = !empty_q;
  end

  assign bus.fifo_full    = full_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.fill_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module   : tb_sync_fifo_param
// Desc     : STD and FWFT FIFOs driven in parallel against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bs ();
  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bf ();

  assign bs.wr_en = wr_en;  assign bs.rd_en = rd_en;
  assign bs.err_clr = err_clr;  assign bs.data_in = data_in;
  assign bf.wr_en = wr_en;  assign bf.rd_en = rd_en;
  assign bf.err_clr = err_clr;  assign bf.data_in = data_in;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .MODE(FIFO_STD))
    u_std (.clk(clk), .rst(rst), .bus(bs));
  sync_fifo_param #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .MODE(FIFO_FWFT))
    u_fwft (.clk(clk), .rst(rst), .bus(bf));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky flags and STD output.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf, m_vld;
  logic [DW-1:0] m_dout;

  always @(posedge clk) begin : model
    bit wa, ra;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_vld = 0; m_dout = '0;
    end else begin
      wa = wr_en && (mq.size() < DEPTH);
      ra = rd_en && (mq.size() > 0);
      if (wr_en && mq.size() == DEPTH) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (rd_en && mq.size() == 0)     m_unf = 1; else if (err_clr) m_unf = 0;
      m_vld = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin : compare
    int n;
    if (chk_en) begin
      n = mq.size();
      check("std_count",  bs.fill_count,   n);
      check("std_full",   bs.fifo_full,    n == DEPTH);
      check("std_empty",  bs.fifo_empty,   n == 0);
      check("std_afull",  bs.almost_full,  n >= 14);
      check("std_aempty", bs.almost_empty, n <= 2);
      check("std_ovf",    bs.overflow,     m_ovf);
      check("std_unf",    bs.underflow,    m_unf);
      check("std_valid",  bs.rd_valid,     m_vld);
      check("std_dout",   bs.data_out,     m_dout);
      check("fwft_count", bf.fill_count,   n);
      check("fwft_full",  bf.fifo_full,    n == DEPTH);
      check("fwft_empty", bf.fifo_empty,   n == 0);
      check("fwft_ovf",   bf.overflow,     m_ovf);
      check("fwft_unf",   bf.underflow,    m_unf);
      check("fwft_valid", bf.rd_valid,     n != 0);
      if (n != 0) check("fwft_dout", bf.data_out, mq[0]);
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en = w; data_in = d; rd_en = r; err_clr = c;
    @(posedge clk);
    @(negedge clk);
    wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("rst_count", bs.fill_count, 0);
    check("rst_empty", bs.fifo_empty, 1);
    check("rst_aempty", bs.almost_empty, 1);
    check("rst_full", bs.fifo_full, 0);
    check("rst_afull", bs.almost_full, 0);
    check("rst_errs", {bs.overflow, bs.underflow}, 0);
    check("rst_valid", bs.rd_valid, 0);
    check("rst_dout", bs.data_out, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1, DW'(i), 0, 0);
      check("fill_afull", bs.almost_full, (i + 1) >= 14);
      check("fill_aempty", bs.almost_empty, (i + 1) <= 2);
    end
    check("fill_count16", bs.fill_count, 16);
    check("fill_full", bs.fifo_full, 1);

    for (int i = 0; i < 16; i++) begin
      check("fwft_head", bf.data_out, i);
      cyc(0, 0, 1, 0);
      check("std_rd_data", bs.data_out, i);
      check("std_rd_valid", bs.rd_valid, 1);
    end
    check("drain_empty", bs.fifo_empty, 1);
    cyc(0, 0, 0, 0);
    check("std_valid_pulse", bs.rd_valid, 0);
    check("std_dout_hold", bs.data_out, 8'h0F);

    for (int i = 0; i < 16; i++) cyc(1, DW'(8'h20 + i), 0, 0);
    cyc(1, 8'hAA, 1, 0);
    check("ovf_set", bs.overflow, 1);
    check("ovf_count", bs.fill_count, 15);
    check("ovf_rd_data", bs.data_out, 8'h20);
    cyc(0, 0, 0, 1);
    check("ovf_clr", bs.overflow, 0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("ovf_drain", bs.data_out, 8'h20 + i);
    end
    check("ovf_drain_empty", bs.fifo_empty, 1);

    cyc(0, 0, 1, 0);
    check("unf_set", bs.underflow, 1);
    check("unf_valid", bs.rd_valid, 0);
    check("unf_count", bs.fill_count, 0);
    cyc(0, 0, 1, 1);
    check("unf_set_beats_clr", bs.underflow, 1);
    cyc(0, 0, 0, 1);
    check("unf_clr", bs.underflow, 0);
    cyc(1, 8'h5C, 1, 0);
    check("both_empty_count", bs.fill_count, 1);
    check("both_empty_unf", bs.underflow, 1);
    check("fwft_5c_data", bf.data_out, 8'h5C);
    check("fwft_5c_valid", bf.rd_valid, 1);
    cyc(0, 0, 1, 0);
    check("fwft_pop_empty", bf.fifo_empty, 1);
    check("fwft_pop_valid", bf.rd_valid, 0);
    check("std_5c_data", bs.data_out, 8'h5C);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 3; i++) cyc(1, DW'(8'h10 + i), 0, 0);
    for (int j = 0; j < 40; j++) begin
      cyc(1, DW'(8'h13 + j), 1, 0);
      check("wrap_count", bs.fill_count, 3);
      check("wrap_std_data", bs.data_out, 8'h10 + j);
      check("wrap_fwft_head", bf.data_out, 8'h11 + j);
    end

    for (int i = 0; i < 6; i++) cyc(1, DW'(8'h60 + i), 0, 0);
    check("pre_rst_count", bs.fill_count, 9);
    rst = 1;
    cyc(1, 8'h77, 1, 0);
    rst = 0;
    check("mid_rst_count", bs.fill_count, 0);
    check("mid_rst_empty", bs.fifo_empty, 1);
    check("mid_rst_errs", {bs.overflow, bs.underflow}, 0);
    check("mid_rst_fwft", bf.fifo_empty, 1);

    // Randomised traffic; bias shifts each phase to drive the FIFO to both extremes.
    for (int p = 0; p < 6; p++) begin
      int wb;
      wb = (p % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 400; k++) begin
        wr_en   = ($urandom_range(0, 99) < wb);
        rd_en   = ($urandom_range(0, 99) < (100 - wb));
        err_clr = ($urandom_range(0, 99) < 4);
        data_in = DW'($urandom);
        rst     = ($urandom_range(0, 299) == 0);
        @(posedge clk);
        @(negedge clk);
      end
    end
    rst = 0; wr_en = 0; rd_en = 0; err_clr = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
